// File: rtl/result_uart_tx.sv
// result_uart_tx: buffers 40-bit result words in a FIFO and sends each as five 8N1 UART bytes, MSB byte first
module result_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_W       = 40,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [DATA_W-1:0]             data,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state, state_n;
    logic [BW-1:0] baud_cnt, baud_n;
    logic [2:0] bit_idx, bit_n, byte_idx, byte_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [7:0] cur;
    logic pop, push, full, bit_end, tx_n;
    assign full = fifo_count == (AW+1)'(FIFO_DEPTH);
    assign push = enable && (!full || pop);
    assign busy = fifo_count != '0 || state != IDLE;
    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_idx;
        byte_n  = byte_idx;
        shreg_n = shreg;
        pop     = 1'b0;
        bit_end = baud_cnt == BW'(CLKS_PER_BIT-1);
        case (state)
            IDLE: if (fifo_count != '0) begin
                pop     = 1'b1;
                shreg_n = mem[rd_ptr];
                byte_n  = '0;
                baud_n  = '0;
                state_n = START;
            end
            START: if (bit_end) begin
                baud_n  = '0;
                bit_n   = '0;
                state_n = DATA;
            end else baud_n = baud_cnt + 1'b1;
            DATA: if (bit_end) begin
                baud_n  = '0;
                bit_n   = bit_idx + 1'b1;
                state_n = bit_idx == 3'd7 ? STOP : DATA;
            end else baud_n = baud_cnt + 1'b1;
            STOP: if (bit_end) begin
                baud_n = '0;
                if (byte_idx == 3'(DATA_W/8-1)) state_n = IDLE;
                else begin
                    byte_n  = byte_idx + 1'b1;
                    shreg_n = shreg << 8;
                    state_n = START;
                end
            end else baud_n = baud_cnt + 1'b1;
            default: state_n = IDLE;
        endcase
        // current byte always sits at the top of the shift register
        cur  = shreg_n[DATA_W-1 -: 8];
        tx_n = state_n == START ? 1'b0 : state_n == DATA ? cur[bit_n] : 1'b1;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            shreg      <= '0;
            tx         <= 1'b1;
            overflow   <= 1'b0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            state      <= state_n;
            baud_cnt   <= baud_n;
            bit_idx    <= bit_n;
            byte_idx   <= byte_n;
            shreg      <= shreg_n;
            tx         <= tx_n;
            overflow   <= overflow | (enable & ~push);
            fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= data;
endmodule

// File: doc/result_uart_tx.md
# result_uart_tx

Streams processor results off-chip over a UART line. Each 40-bit `data` word the processor flags with its `enable` strobe is captured into a small FIFO and serialized as five 8N1 bytes, most-significant byte first. The block sits at the processor's result output and is the hardware counterpart of the bench-side result dump. A host-side receiver rebuilds the identical word sequence.

## Interface
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal minimum 2
- DATA_W, 40, result word width; fixed at 40 (5 bytes)
- FIFO_DEPTH, 4, words buffered ahead of the shift register; power of 2
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- enable  in  1  result-valid strobe; one word captured per cycle high
- data  in  40  result word, sampled when enable=1
- tx  out  1  UART serial line, idle high
- busy  out  1  high while FIFO non-empty or a frame is in progress
- overflow  out  1  sticky; set when a word is dropped, cleared only by reset
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words currently in FIFO

## Operation
- Reset values: tx=1, busy=0, overflow=0, fifo_count=0. FIFO pointers are cleared and FSM=IDLE.
- Push: enable=1 at a rising edge writes `data` to the FIFO.
  - If the FIFO is full and no pop occurs that edge, the word is dropped and overflow is set.
  - Push and pop on the same edge when full: the push is accepted and the count is unchanged.
- FSM states: IDLE, START, DATA, STOP. Counters: baud_cnt (0..CLKS_PER_BIT-1), bit_idx (0..7), byte_idx (0..4).
- IDLE: tx=1. If the FIFO is non-empty, pop the head into a 40-bit shift register, set byte_idx=0, and go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
- DATA: tx = bit bit_idx of the current byte, LSB first. Each bit is held CLKS_PER_BIT cycles; after bit 7, go to STOP.
- Current byte = data[39:32] for byte_idx 0, down to data[7:0] for byte_idx 4.
- STOP: tx=1 for CLKS_PER_BIT cycles.
  - If byte_idx<4: increment byte_idx and go to START.
  - Otherwise go to IDLE.
- tx is registered; no combinational path exists from the inputs to tx.
- Reset mid-frame aborts immediately: tx=1, FIFO contents are discarded, and no partial byte is resumed.

## Timing
- Capture: enable at edge N makes fifo_count≥1 after edge N.
- FSM pop happens at edge N+1, where tx falls to the start bit; capture-to-start latency is 1 cycle from an empty, idle state.
- Bit period: exactly CLKS_PER_BIT cycles. Byte frame: 10×CLKS_PER_BIT. Word: 50×CLKS_PER_BIT.
- Bytes within a word are back-to-back: a STOP is followed directly by the next START with no gap.
- Between words there is exactly one IDLE cycle (tx=1) after the final stop bit before the next start bit.
- busy falls on the edge the FSM returns to IDLE with the FIFO empty.
- Sustained rate limit: one word per 50×CLKS_PER_BIT+1 cycles. Bursts beyond FIFO_DEPTH+1 words overflow.
- overflow asserts on the edge of the dropped push.

## Test plan
- **Single word** (CLKS_PER_BIT=4, data=0x123456789A, enable for 1 cycle):
  - tx falls 1 cycle after capture.
  - The bench UART model decodes 0x12, 0x34, 0x56, 0x78, 0x9A.
  - The frame spans 200 cycles; busy drops afterwards; overflow=0.
- **Burst overflow** (enable high 6 consecutive cycles, words 0x01..0x06, FIFO_DEPTH=4):
  - Words 0x01–0x05 are transmitted in order and 0x06 is dropped.
  - overflow=1 from the 6th push edge; fifo_count peaks at 4.
- **Back-to-back spacing** (two words pushed on consecutive cycles):
  - There is no gap between bytes within a word.
  - There is exactly 1 idle-high cycle between the stop bit of byte 4 and the next start bit.
- **Simultaneous push/pop at full** (FIFO full with the FSM finishing a word):
  - Push on the same edge as the IDLE pop is accepted; fifo_count stays 4; overflow stays 0.
- **Reset mid-frame** (assert rst low during the DATA state of byte 2):
  - tx=1, busy=0, fifo_count=0, overflow=0 immediately (asynchronous).
  - After release, a new word is transmitted cleanly from byte 0.
- **Result-stream replay** (drive a processor-style stream of 12 words with irregular enable gaps of at least 50×CLKS_PER_BIT+1 cycles):
  - The decoded byte stream reassembles to the 12 words exactly, in order, with overflow=0.
